stripe_lane_arbiter: RTL

//  Round-robin scheduler sharing the byte-striping datapath among N_CH channel FIFOs.
//  - Grants one channel per burst and pops bytes from it.
//  - Drives a byte stream at clk_2f into the byte striping stage, which splits it onto lanes 0/1.
//  - Keeps every burst an even number of bytes, so the unstripping stage always pairs stripe 0/1 correctly.

---
 rtl/stripe_pkg.sv | 13 +
 rtl/stripe_lane_arbiter_rr_grant.sv | 29 ++
 rtl/stripe_lane_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/stripe_pkg.sv
// Shared definitions for the byte striping / unstripping path and the
// lane arbiter that feeds it: FSM state encoding and the default filler byte.
package stripe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    PAD  = 2'd2
  } state_t;

  localparam logic [7:0] PAD_BYTE_DEFAULT = 8'hBC;

endpackage

// File: rtl/stripe_lane_arbiter_rr_grant.sv
// rr_grant: combinational rotating priority encoder.
// Searches req starting just after ptr and wrapping round to ptr itself;
// the first set request wins.
module rr_grant #(
  parameter int N_CH = 4,
  parameter int CHW  = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CHW-1:0]  ptr,
  output logic [CHW-1:0]  gnt_idx,
  output logic            gnt_any
);

  // Walk from the farthest candidate to the nearest so the nearest hit is the last write
  always_comb begin
    logic [CHW-1:0] cand;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand = CHW'((int'(ptr) + k) % N_CH);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stripe_lane_arbiter.sv
// stripe_lane_arbiter: round-robin scheduler that shares the byte striping
// datapath among N_CH show-ahead channel FIFOs. Each grant moves up to
// BURST_LEN bytes; an odd-length burst is completed with one PAD_BYTE so the
// striping stage always sees an even byte count per burst.
// Optional build macro STRIPE_ARB_PRIO_EN: channel 0 wins every arbitration
// it requests and does not move the round-robin pointer.
module stripe_lane_arbiter
  import stripe_pkg::*;
#(
  parameter int          N_CH      = 4,
  parameter int          BURST_LEN = 8,
  parameter logic [7:0]  PAD_BYTE  = PAD_BYTE_DEFAULT,
  localparam int         CHW       = $clog2(N_CH)
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [N_CH-1:0]   fifo_empty,
  input  logic [8*N_CH-1:0] fifo_data,
  output logic [N_CH-1:0]   fifo_pop,
  input  logic              stripe_pause,
  output logic [7:0]        data_out,
  output logic              valid_out,
  output logic              pad_out,
  output logic [CHW-1:0]    ch_out,
  output logic              busy
);

  localparam int             CNTW     = $clog2(BURST_LEN + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST_LEN - 1);

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [CHW-1:0]    sel;
  logic [CHW-1:0]    rr_ptr;

  logic [N_CH-1:0]   req;
  logic [CHW-1:0]    rr_idx;
  logic              rr_any;
  logic [CHW-1:0]    win_idx;
  logic              win_any;
  logic              win_upd;
  logic              sel_empty;
  logic [7:0]        sel_data;
  logic              can_pop;

  assign req = ~fifo_empty;

  rr_grant #(
    .N_CH (N_CH),
    .CHW  (CHW)
  ) u_rr_grant (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

`ifdef STRIPE_ARB_PRIO_EN
  // Channel 0 pre-empts the rotation and leaves the pointer where it was
  always_comb begin
    win_idx = rr_idx;
    win_any = rr_any;
    win_upd = rr_any;
    if (req[0]) begin
      win_idx = '0;
      win_any = 1'b1;
      win_upd = 1'b0;
    end
  end
`else
  // Pure rotation: every winner becomes the new pointer
  always_comb begin
    win_idx = rr_idx;
    win_any = rr_any;
    win_upd = rr_any;
  end
`endif

  assign sel_empty = fifo_empty[sel];
  assign sel_data  = fifo_data[{sel, 3'b000} +: 8];
  assign can_pop   = (state == XFER) && !sel_empty && !stripe_pause && !reset;
  assign busy      = (state != IDLE);

  // One-hot pop of the granted channel; the head byte is taken at this edge
  always_comb begin
    fifo_pop = '0;
    if (can_pop) fifo_pop[sel] = 1'b1;
  end

  // Burst FSM with registered byte-stream outputs; pause freezes all progress
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      rr_ptr    <= CHW'(N_CH - 1);
      data_out  <= '0;
      valid_out <= 1'b0;
      pad_out   <= 1'b0;
      ch_out    <= '0;
    end else begin
      valid_out <= 1'b0;
      pad_out   <= 1'b0;
      if (!stripe_pause) begin
        case (state)
          IDLE: begin
            if (win_any) begin
              sel   <= win_idx;
              cnt   <= '0;
              state <= XFER;
              if (win_upd) rr_ptr <= win_idx;
            end
          end
          XFER: begin
            if (!sel_empty) begin
              data_out  <= sel_data;
              valid_out <= 1'b1;
              ch_out    <= sel;
              cnt       <= cnt + 1'b1;
              if (cnt == CNT_LAST) state <= IDLE;
            end else if (cnt[0]) begin
              state <= PAD;
            end else begin
              state <= IDLE;
            end
          end
          PAD: begin
            data_out  <= PAD_BYTE;
            valid_out <= 1'b1;
            pad_out   <= 1'b1;
            ch_out    <= sel;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
